// File: rtl/lib_switchblock_pkg.sv
// Shared definitions for the DEM switching-block tree and its controller.
package lib_switchblock_pkg;

    localparam int INPUT_WIDTH = 8;
    localparam int TREE_DEPTH  = 3;
    localparam int NUM_LEAVES  = 8;
    // Eight leaves need three guard bits so their sum cannot overflow.
    localparam int SUM_W       = INPUT_WIDTH + 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StFault = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/dem_tag_pipe.sv
// Fixed-latency delay line carrying a valid bit and a sample, with synchronous flush.
module dem_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_sr [DEPTH];
    logic [WIDTH-1:0] data_sr  [DEPTH];

    // Shift one slot per cycle; reset and flush empty every slot.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_sr[i] <= 1'b0;
                data_sr[i]  <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            data_sr[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                data_sr[i]  <= data_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/dem_tree_ctrl.sv
// Sequencing controller for the 3-layer DEM tree: intake, clamp, latency tracking,
// output registration, sum-conservation check and event counters.
module dem_tree_ctrl #(
    parameter int INPUT_WIDTH = lib_switchblock_pkg::INPUT_WIDTH,
    parameter int NUM_OUT     = lib_switchblock_pkg::NUM_LEAVES,
    parameter int TREE_LAT    = 3,
    parameter int CLAMP_HI    = 2**(INPUT_WIDTH-1) - 1,
    parameter int CLAMP_LO    = -(2**(INPUT_WIDTH-1) - 1),
    parameter int IDLE_CODE   = 0,
    parameter int CNT_W       = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic                           clear_i,
    input  logic                           in_valid_i,
    input  logic [INPUT_WIDTH-1:0]         in_data_i,
    output logic                           in_ready_o,
    output logic [INPUT_WIDTH-1:0]         tree_x_o,
    output logic                           tree_rst_o,
    input  logic [NUM_OUT*INPUT_WIDTH-1:0] tree_out_i,
    output logic                           out_valid_o,
    output logic [NUM_OUT*INPUT_WIDTH-1:0] out_data_o,
    output logic [1:0]                     state_o,
    output logic                           err_o,
    output logic [CNT_W-1:0]               sample_cnt_o,
    output logic [7:0]                     clamp_cnt_o,
    output logic [7:0]                     underrun_cnt_o
);

    import lib_switchblock_pkg::*;

    localparam int SumW   = INPUT_WIDTH + 3;
    localparam int ExtW   = SumW - INPUT_WIDTH;
    localparam int DrainW = $clog2(TREE_LAT + 1) + 1;

    ctrl_state_t                   state, state_next;
    logic [DrainW-1:0]             drain_cnt;
    logic                          accept, flush, mismatch;
    logic signed [INPUT_WIDTH-1:0] clamped;
    logic                          was_clamped;
    logic                          acc_tag;
    logic                          tag_valid;
    logic [INPUT_WIDTH-1:0]        tag_data;
    logic signed [SumW-1:0]        leaf_sum, tag_ext;

    assign in_ready_o = (state == StRun);
    assign accept     = in_valid_i && in_ready_o;
    assign state_o    = state;

    // Saturate the incoming sample into [CLAMP_LO, CLAMP_HI].
    always_comb begin
        clamped = $signed(in_data_i);
        if ($signed(in_data_i) > CLAMP_HI) begin
            clamped = INPUT_WIDTH'(CLAMP_HI);
        end else if ($signed(in_data_i) < CLAMP_LO) begin
            clamped = INPUT_WIDTH'(CLAMP_LO);
        end
        was_clamped = (clamped != $signed(in_data_i));
    end

    // Sum the sign-extended leaves and compare with the sample that produced them.
    always_comb begin
        leaf_sum = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            leaf_sum = leaf_sum + $signed({{ExtW{tree_out_i[k*INPUT_WIDTH+INPUT_WIDTH-1]}},
                                           tree_out_i[k*INPUT_WIDTH +: INPUT_WIDTH]});
        end
        tag_ext  = $signed({{ExtW{tag_data[INPUT_WIDTH-1]}}, tag_data});
        mismatch = tag_valid && (state != StIdle) && (leaf_sum != tag_ext);
    end

    // Next-state logic; a mismatch outranks both the drain request and drain completion.
    always_comb begin
        state_next = state;
        unique case (state)
            StIdle: begin
                if (enable_i) state_next = StRun;
            end
            StRun: begin
                if (mismatch)       state_next = StFault;
                else if (!enable_i) state_next = StDrain;
            end
            StDrain: begin
                if (mismatch)                             state_next = StFault;
                else if (drain_cnt == DrainW'(TREE_LAT)) state_next = StIdle;
            end
            StFault: begin
                if (clear_i) state_next = StIdle;
            end
            default: state_next = StIdle;
        endcase
    end

    // In-flight tags are discarded whenever the controller parks in IDLE or FAULT.
    assign flush = (state_next == StIdle) || (state_next == StFault);

    // State register and drain-cycle counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= StIdle;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == StDrain) ? drain_cnt + DrainW'(1) : '0;
        end
    end

    // Tree drive: registered sample/idle code, tree reset and the first tag stage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tree_x_o   <= INPUT_WIDTH'(IDLE_CODE);
            tree_rst_o <= 1'b1;
            acc_tag    <= 1'b0;
        end else begin
            tree_x_o   <= accept ? clamped : INPUT_WIDTH'(IDLE_CODE);
            tree_rst_o <= flush;
            acc_tag    <= accept && !flush;
        end
    end

    // tree_x_o acts as the first stage, so the pipe adds the remaining TREE_LAT cycles.
    dem_tag_pipe #(
        .DEPTH (TREE_LAT),
        .WIDTH (INPUT_WIDTH)
    ) u_tag_pipe (
        .clk       (clk_i),
        .reset     (reset_i),
        .flush     (flush),
        .in_valid  (acc_tag),
        .in_data   (tree_x_o),
        .out_valid (tag_valid),
        .out_data  (tag_data)
    );

    // Output register and sticky fault; a bad slot never raises out_valid_o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            out_valid_o <= tag_valid && !mismatch;
            if (tag_valid && !mismatch) begin
                out_data_o <= tree_out_i;
            end
            if (mismatch) begin
                err_o <= 1'b1;
            end else if (clear_i) begin
                err_o <= 1'b0;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            sample_cnt_o   <= '0;
            clamp_cnt_o    <= '0;
            underrun_cnt_o <= '0;
        end else begin
            if (accept && (sample_cnt_o != '1)) begin
                sample_cnt_o <= sample_cnt_o + CNT_W'(1);
            end
            if (accept && was_clamped && (clamp_cnt_o != '1)) begin
                clamp_cnt_o <= clamp_cnt_o + 8'd1;
            end
            if ((state == StRun) && !in_valid_i && (underrun_cnt_o != '1)) begin
                underrun_cnt_o <= underrun_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: doc/dem_tree_ctrl.md
Name: dem_tree_ctrl

Overview:
Sequencing controller for the 3-layer, 8-output DEM switching-block tree. Accepts input samples over a valid/ready handshake, clamps them, drives the tree input and tree reset, and tracks in-flight samples through the tree latency. Registers the 8 tree outputs with an aligned valid and checks per-sample sum conservation. Provides run/drain/fault sequencing and saturating event counters for the DAC front end.

Parameters:
INPUT_WIDTH, lib_switchblock_pkg::INPUT_WIDTH, signed sample width (tree input and each tree output)
NUM_OUT, 8, tree leaf count; fixed at 8 for the 3-layer tree
TREE_LAT, 3, tree latency in cycles from tree_x_o to tree_out_i; minimum 1
CLAMP_HI, 2**(INPUT_WIDTH-1)-1, upper clamp limit, signed
CLAMP_LO, -(2**(INPUT_WIDTH-1)-1), lower clamp limit, signed; the most-negative code is excluded
IDLE_CODE, 0, value driven into the tree on cycles with no accepted sample
CNT_W, 16, width of the sample counter

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  level; high starts and keeps streaming; low requests drain
clear_i  in  1  pulse; clears fault and counters
in_valid_i  in  1  sample valid
in_data_i  in  INPUT_WIDTH  signed sample
in_ready_o  out  1  controller accepts a sample this cycle
tree_x_o  out  INPUT_WIDTH  registered signed drive to the tree input
tree_rst_o  out  1  registered reset to the tree instances
tree_out_i  in  NUM_OUT*INPUT_WIDTH  packed tree leaves; leaf k is at [k*W +: W]
out_valid_o  out  1  out_data_o holds a tree result for an accepted sample
out_data_o  out  NUM_OUT*INPUT_WIDTH  registered leaves
state_o  out  2  current FSM state encoding
err_o  out  1  sticky sum-mismatch fault
sample_cnt_o  out  CNT_W  accepted samples, saturating
clamp_cnt_o  out  8  clamped samples, saturating
underrun_cnt_o  out  8  RUN cycles with in_valid_i low, saturating

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: state IDLE; tree_x_o = IDLE_CODE; tree_rst_o = 1; out_valid_o = 0; out_data_o = 0; err_o = 0; all counters = 0; tag pipe = 0.
- FSM states: IDLE=0, RUN=1, DRAIN=2, FAULT=3.
  - IDLE -> RUN when enable_i = 1. tree_rst_o deasserts on the same edge.
  - RUN -> DRAIN when enable_i = 0.
  - DRAIN -> IDLE after TREE_LAT+1 cycles in DRAIN. During DRAIN, enable_i is ignored.
  - Any state except IDLE -> FAULT on a sum mismatch.
  - FAULT -> IDLE on clear_i.
- tree_rst_o: 1 in IDLE and FAULT; 0 in RUN and DRAIN.
- Handshake:
  - in_ready_o = (state == RUN), combinational from state only.
  - A sample is accepted on an edge where in_valid_i & in_ready_o.
  - Any cycle that is not an accept edge drives tree_x_o = IDLE_CODE. This includes RUN underrun cycles and all DRAIN cycles.
- Clamp:
  - Accepted sample x becomes min(max(x, CLAMP_LO), CLAMP_HI) before loading tree_x_o.
  - clamp_cnt_o increments when the clamped value differs from x.
- Tag pipe:
  - TREE_LAT-deep shift register carries {accepted bit, clamped sample}.
  - On edge n+TREE_LAT+1 after accept edge n: out_data_o <= tree_out_i and out_valid_o <= 1. Latency is TREE_LAT+1 cycles (default 4).
  - For non-tagged slots, out_valid_o = 0 and out_data_o holds its previous value.
- Sum check:
  - On each tagged slot, sign-extend the leaves to INPUT_WIDTH+3 bits and sum them; compare with the sign-extended tagged sample.
  - On mismatch: err_o <= 1, state -> FAULT, out_valid_o <= 0 for that slot.
  - The tag pipe is flushed when entering FAULT and IDLE.
- Counters:
  - sample_cnt_o increments on each accept.
  - underrun_cnt_o increments on each RUN cycle with in_valid_i = 0.
  - All counters saturate at all-ones.
  - clear_i zeroes all counters, in any state.
- Simultaneous events:
  - clear_i has priority over a same-cycle increment.
  - A mismatch in the same cycle as enable_i falling goes to FAULT, not DRAIN.
  - clear_i in FAULT with a fresh mismatch in the same cycle is impossible, because the pipe is flushed.
- Reset mid-operation: returns all registers to reset values on the next edge and discards in-flight samples without an out_valid_o.

Decomposition:
- lib_switchblock_pkg adds the following; INPUT_WIDTH already lives there:
  - ctrl_state_t, an enum for IDLE/RUN/DRAIN/FAULT;
  - TREE_DEPTH = 3;
  - NUM_LEAVES = 8;
  - SUM_W = INPUT_WIDTH+3.
- One sub-module: dem_tag_pipe, the TREE_LAT-deep valid+sample delay line with a synchronous flush input.

Test Plan:
1. Reset, then enable_i = 1 and samples 5, -3, 0, 7 back-to-back with leaves summing correctly -> out_valid_o high on edges 4–7 after first accept; sample_cnt_o = 4; err_o = 0.
2. in_data_i = 127 with CLAMP_HI = 100 (W = 8) -> tree_x_o = 100; clamp_cnt_o = 1; sum check is against 100.
3. RUN with in_valid_i low for 3 cycles -> tree_x_o = IDLE_CODE; underrun_cnt_o = 3; no out_valid_o for those slots.
4. enable_i dropped with 3 samples in flight -> DRAIN; in_ready_o = 0; 3 out_valid_o pulses; IDLE after TREE_LAT+1 cycles; tree_rst_o = 1.
5. Force one leaf +1 on a tagged slot -> err_o = 1, state_o = 3, out_valid_o = 0; clear_i -> state_o = 0, err_o = 0, counters = 0.
6. reset_i pulse mid-RUN with 2 samples in flight -> no out_valid_o afterwards; all outputs at reset values on the next edge.
